// File: rtl/inst_mem_pkg.sv
// ============================================================================
// inst_mem_pkg -- shared fault codes, NOP encoding and response record
// Revision: 1.0
// ============================================================================
`default_nettype none

package inst_mem_pkg;

  localparam logic [1:0]  FAULT_OK       = 2'd0;
  localparam logic [1:0]  FAULT_MISALIGN = 2'd1;
  localparam logic [1:0]  FAULT_RANGE    = 2'd2;

  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [31:0] inst;
    logic [1:0]  fault;
  } resp_t;

endpackage

`default_nettype wire

// File: rtl/inst_ram_1r1w.sv
// ============================================================================
// inst_ram_1r1w -- 2^DEPTH_LOG2 x 32 array, one sync read, one write, read-first
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_ram_1r1w #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // Non-blocking update of both gives old data on a same-word collision.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/inst_mem_resp.sv
// ============================================================================
// inst_mem_resp -- instruction-fetch responder: fault check, array read,
//                  LATENCY-stage response pipe with flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_mem_resp
  import inst_mem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_ena,
  input  logic [63:0]           inst_addr,
  input  logic                  flush,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_inst,
  output logic [63:0]           resp_addr,
  output logic [1:0]            resp_fault
);

  localparam logic [64:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (65'd1 << (DEPTH_LOG2 + 2));

  logic [1:0]            fault_d;
  logic [63:0]           offset_d;
  logic [DEPTH_LOG2-1:0] idx_d;
  logic                  ram_re;
  logic [31:0]           ram_rdata;

  logic                  s0_valid_q;
  logic                  s0_loaded_q;
  logic [63:0]           s0_addr_q;
  logic [1:0]            s0_fault_q;

  resp_t                 w_stage [LATENCY];

  always_comb begin
    fault_d = FAULT_OK;
    if (inst_addr[1:0] != 2'b00) begin
      fault_d = FAULT_MISALIGN;
    end else if (({1'b0, inst_addr} < {1'b0, BASE_ADDR}) ||
                 ({1'b0, inst_addr} >= ADDR_LIMIT)) begin
      fault_d = FAULT_RANGE;
    end
  end

  assign offset_d = inst_addr - BASE_ADDR;
  assign idx_d    = DEPTH_LOG2'(offset_d >> 2);
  assign ram_re   = inst_ena && (fault_d == FAULT_OK);

  inst_ram_1r1w #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .re_i    (ram_re),
    .raddr_i (idx_d),
    .rdata_o (ram_rdata),
    .we_i    (ld_we),
    .waddr_i (ld_addr),
    .wdata_i (ld_data)
  );

  // Stage 1 ignores flush: the request sampled alongside it is the redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      s0_loaded_q <= 1'b0;
      s0_addr_q   <= '0;
      s0_fault_q  <= FAULT_OK;
    end else begin
      s0_valid_q <= inst_ena;
      if (inst_ena) begin
        s0_loaded_q <= 1'b1;
        s0_addr_q   <= inst_addr;
        s0_fault_q  <= fault_d;
      end
    end
  end

  // Until the first request the uninitialised read register is masked to zero.
  assign w_stage[0].valid = s0_valid_q;
  assign w_stage[0].addr  = s0_addr_q;
  assign w_stage[0].fault = s0_fault_q;
  assign w_stage[0].inst  = !s0_loaded_q                ? 32'h0    :
                            (s0_fault_q != FAULT_OK)    ? NOP_INST : ram_rdata;

  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    resp_t stage_q;
    logic  w_load;

    assign w_load = w_stage[i-1].valid && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '0;
      end else begin
        stage_q.valid <= w_load;
        if (w_load) begin
          stage_q.addr  <= w_stage[i-1].addr;
          stage_q.inst  <= w_stage[i-1].inst;
          stage_q.fault <= w_stage[i-1].fault;
        end
      end
    end

    assign w_stage[i] = stage_q;
  end

  assign resp_valid = w_stage[LATENCY-1].valid;
  assign resp_inst  = w_stage[LATENCY-1].inst;
  assign resp_addr  = w_stage[LATENCY-1].addr;
  assign resp_fault = w_stage[LATENCY-1].fault;

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_resp.sv
// ============================================================================
// tb_inst_mem_resp -- directed self-checking bench, LATENCY 1/2/3 instances
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ena;
  logic [63:0] inst_addr;
  logic        flush;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        v1, v2, v3;
  logic [31:0] i1, i2, i3;
  logic [63:0] a1, a2, a3;
  logic [1:0]  f1, f2, f3;

  int checks = 0;
  int errors = 0;

  logic [31:0] words [4];
  logic        alt_ena [8];

  always #5 clk = ~clk;

  inst_mem_resp #(.BASE_ADDR(64'h0), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inst_ena(inst_ena), .inst_addr(inst_addr), .flush(flush),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .resp_valid(v1), .resp_inst(i1), .resp_addr(a1), .resp_fault(f1));

  inst_mem_resp #(.BASE_ADDR(64'h0), .DEPTH_LOG2(10), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .inst_ena(inst_ena), .inst_addr(inst_addr), .flush(flush),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .resp_valid(v2), .resp_inst(i2), .resp_addr(a2), .resp_fault(f2));

  inst_mem_resp #(.BASE_ADDR(64'h0), .DEPTH_LOG2(10), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .inst_ena(inst_ena), .inst_addr(inst_addr), .flush(flush),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .resp_valid(v3), .resp_inst(i3), .resp_addr(a3), .resp_fault(f3));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = idx[9:0];
    ld_data = d;
    step();
    ld_we   = 1'b0;
  endtask

  task automatic req(input logic ena, input logic [63:0] addr);
    inst_ena  = ena;
    inst_addr = addr;
  endtask

  initial begin
    words[0] = 32'h0000_0093;
    words[1] = 32'h0010_0113;
    words[2] = 32'h0020_0193;
    words[3] = 32'h0030_0213;
    alt_ena  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; inst_ena = 1'b0; inst_addr = '0; flush = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    step(); step();
    check("rst_valid", {61'd0, v1, v2, v3}, 64'd0);
    check("rst_inst", {i1, i2}, 64'd0);
    check("rst_addr", a3, 64'd0);
    check("rst_fault", {58'd0, f1, f2, f3}, 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) load(k, words[k]);
    load(5, 32'h0050_0293);
    load(16, 32'h0100_0513);

    // Back-to-back fetches
    for (int k = 0; k < 6; k++) begin
      req(k < 4, 64'(4 * k));
      step();
      if (k < 4) check("l1_inst", i1, words[k]);
      if (k >= 1 && k <= 4) begin
        check("l2_valid", v2, 1'b1);
        check("l2_inst", i2, words[k-1]);
        check("l2_addr", a2, 64'(4 * (k - 1)));
        check("l2_fault", f2, 2'd0);
      end
      if (k == 5) begin
        check("l2_bubble_valid", v2, 1'b0);
        check("l2_hold_inst", i2, words[3]);
      end
    end

    // Faults
    req(1'b1, 64'h6);      step();
    check("mis_fault", f1, 2'd1);
    check("mis_inst", i1, 32'h13);
    req(1'b1, 64'hFFC);    step();
    check("last_word_fault", f1, 2'd0);
    req(1'b1, 64'h1000);   step();
    check("range_fault", f1, 2'd2);
    check("range_inst", i1, 32'h13);
    check("range_valid", v1, 1'b1);
    req(1'b1, 64'h1002);   step();
    check("prio_fault", f1, 2'd1);
    check("l2_range_addr", a2, 64'h1000);
    check("l2_range_fault", f2, 2'd2);
    req(1'b0, 64'h0);      step();
    check("l2_prio_fault", f2, 2'd1);
    step(); step();

    // Flush with redirect target sampled in the same cycle
    req(1'b1, 64'h0);  step();
    req(1'b1, 64'h4);  step();
    req(1'b1, 64'h8);  step();
    req(1'b1, 64'h40); flush = 1'b1; step();
    flush = 1'b0; req(1'b0, 64'h0);
    check("fl_l3_valid0", v3, 1'b0);
    check("fl_l2_valid0", v2, 1'b0);
    check("fl_l1_valid", v1, 1'b1);
    check("fl_l1_addr", a1, 64'h40);
    step();
    check("fl_l3_valid1", v3, 1'b0);
    check("fl_l2_addr", {a2[62:0], v2}, {63'h40, 1'b1});
    step();
    check("fl_l3_valid2", v3, 1'b1);
    check("fl_l3_addr", a3, 64'h40);
    check("fl_l3_inst", i3, 32'h0100_0513);
    step();
    check("fl_l3_after", v3, 1'b0);

    // Loader collision: read-first
    ld_we = 1'b1; ld_addr = 10'd5; ld_data = 32'hDEAD_BEEF;
    req(1'b1, 64'h14); step();
    ld_we = 1'b0;
    check("coll_old", i1, 32'h0050_0293);
    req(1'b1, 64'h14); step();
    check("coll_new", i1, 32'hDEAD_BEEF);
    req(1'b0, 64'h0); step(); step(); step();

    // Alternating inst_ena
    for (int k = 0; k < 8; k++) begin
      req(alt_ena[k], 64'(8 * k));
      step();
      check("alt_l1", v1, alt_ena[k]);
      if (k >= 1) check("alt_l2", v2, alt_ena[k-1]);
      if (k >= 2) check("alt_l3", v3, alt_ena[k-2]);
    end

    // Asynchronous reset with responses in flight
    req(1'b1, 64'h0); step();
    req(1'b1, 64'h4); step();
    req(1'b0, 64'h0);
    check("pre_rst_l2", v2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {61'd0, v1, v2, v3}, 64'd0);
    check("async_inst", i2, 32'd0);
    check("async_addr", a2, 64'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_valid", {61'd0, v1, v2, v3}, 64'd0);
    end
    req(1'b1, 64'h14); step();
    check("array_kept5", i1, 32'hDEAD_BEEF);
    req(1'b1, 64'h8); step();
    check("array_kept2", i1, words[2]);
    req(1'b0, 64'h0); step();
    check("post_rst_l3", {a3[62:0], v3}, {63'h14, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_mem_resp.md
# inst_mem_resp

Responder end of the instruction-fetch interface. It samples the fetch stage's `inst_addr`/`inst_ena` every cycle, reads a 32-bit instruction from an on-chip word array, and returns it after a fixed `LATENCY`, together with the echoed address and a fault code. A loader write port fills the array, and a flush input discards in-flight responses when the PC is redirected.

## Interface
- `BASE_ADDR`, default 64'h0000_0000: byte address of array word 0.
- `DEPTH_LOG2`, default 10: array holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 1, legal 1..4: cycles from request sample to `resp_valid`.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `inst_ena` input 1: fetch request valid this cycle.
- `inst_addr` input 64: fetch byte address.
- `flush` input 1: kill all in-flight responses.
- `ld_we` input 1: loader write strobe.
- `ld_addr` input DEPTH_LOG2: loader word index.
- `ld_data` input 32: loader write data.
- `resp_valid` output 1: response valid.
- `resp_inst` output 32: instruction word.
- `resp_addr` output 64: address of the request being answered.
- `resp_fault` output 2: 0 = ok, 1 = misaligned, 2 = out of range.

## Operation
- Request accepted in every cycle with `inst_ena`=1. There is no backpressure, and one response is produced per request, in order.
- Fault check happens at sample time. Misaligned means `inst_addr[1:0]`≠0. Out of range means `inst_addr` < `BASE_ADDR` or `inst_addr` ≥ `BASE_ADDR`+4·2^DEPTH_LOG2, computed in 64 bits with no wrap. Misaligned takes priority over out of range.
- Word index = (`inst_addr`−`BASE_ADDR`)[DEPTH_LOG2+1:2].
- Faulted response: `resp_inst`=32'h0000_0013 (NOP), `resp_fault` set, `resp_valid`=1. The array is not read.
- Read-first collision rule: if a loader write and a read hit the same word in the same cycle, the read returns the old data.
- The loader may write in any cycle, concurrently with fetches.
- Pipeline: LATENCY stages, each holding {valid, addr, fault}. Stage 1 also holds the synchronous array read.
- Flush:
  - Clears valid in all stages at the clock edge.
  - A request sampled in the same cycle as `flush` is kept, because it is the redirect target.
  - `resp_valid` is 0 in the cycle after flush unless LATENCY=1 and that kept request is being answered.
- `inst_ena`=0 inserts a bubble: the stage valid is 0 and data/addr hold their last values.

## Timing
- Reset values: `resp_valid`=0, `resp_inst`=0, `resp_addr`=0, `resp_fault`=0, all stage valids 0.
- The array is not reset; its contents survive `rst_n`.
- Request at edge N produces its response on outputs after edge N+LATENCY-1. With LATENCY=1, outputs are registered and valid in the cycle after the request.
- Reset asserted mid-stream drops all in-flight responses immediately (asynchronous). The first request after deassertion is sampled at the first rising edge with `rst_n`=1.
- Back-to-back requests give back-to-back responses at full throughput.
- Outputs hold their values while `resp_valid`=0; consumers qualify on valid.

## Structure
- Shared package `inst_mem_pkg`:
  - `FAULT_OK`/`FAULT_MISALIGN`/`FAULT_RANGE` localparams.
  - `NOP_INST` constant.
  - Response struct {valid, addr[63:0], inst[31:0], fault[1:0]}.
- Sub-module `inst_ram_1r1w`: 2^DEPTH_LOG2×32, one synchronous read port, one write port, read-first, no reset.
- Top level holds the fault check, the stage shift register, and the flush logic, generated for LATENCY.

## Test plan
- Load words 0..3 = 32'h00000093, 32'h00100113, 32'h00200193, 32'h00300213. Fetch 0x0,0x4,0x8,0xC back-to-back with LATENCY=2 -> same four words on four consecutive cycles starting 2 cycles after the first request, with `resp_addr` echoed and fault 0.
- Fetch 0x6 -> fault 1 and `resp_inst`=0x00000013. Fetch `BASE_ADDR`+0x1000 with DEPTH_LOG2=10 -> fault 2. Fetch 0x1002 -> fault 1 (priority).
- LATENCY=3: issue requests 0x0,0x4,0x8, assert `flush` with a request for 0x40 in the next cycle -> only the 0x40 response appears, 3 cycles later.
- Loader writes word 5 = 32'hDEADBEEF while a fetch of 0x14 occurs in the same cycle -> response carries the old value. A refetch of 0x14 returns 32'hDEADBEEF.
- Drop `rst_n` asynchronously with 2 responses in flight -> `resp_valid` falls to 0 without waiting for a clock edge, and no stale response appears after release. Array contents are unchanged.
- Alternate `inst_ena` 1/0 -> `resp_valid` pattern matches, delayed by LATENCY.
